// File: rtl/ahbl_sram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ahbl_sram_bank_ctrl
// Purpose  : Back-end stage of the AHB-Lite SRAM interface. Accepts one
//            byte/halfword/word request at a time on the ahbsram_* channel,
//            drives a single-port synchronous SRAM bank with byte enables and
//            returns a one-cycle ack, read data and BUSY. Word addresses at or
//            beyond NUM_LOCATIONS are absorbed: writes are dropped and reads
//            return zero.
// Ports    : HCLK, HRESETN             - clock, async active-low reset
//            ahbsram_req/write/wdata/
//            size/addr                 - request channel from interface stage
//            sramahb_ack/rdata, BUSY   - completion channel to interface stage
//            ram_addr/wdata/be/we/re   - SRAM command outputs
//            ram_rdata                 - SRAM read data, one cycle after ram_re
// Config   : `define AHBL_SRAM_RDATA_PIPE_EN adds the RPIPE state and a second
//            read-data register stage (read ack moves from cycle 3 to 4).
// Revision : 1.0 - initial release
// ============================================================================
module ahbl_sram_bank_ctrl #(
  parameter int NUM_LOCATIONS = 512,
  parameter int RAM_AWIDTH    = 9
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  ahbsram_req,
  input  logic                  ahbsram_write,
  input  logic [31:0]           ahbsram_wdata,
  input  logic [2:0]            ahbsram_size,
  input  logic [19:0]           ahbsram_addr,
  output logic                  sramahb_ack,
  output logic [31:0]           sramahb_rdata,
  output logic                  BUSY,
  output logic [RAM_AWIDTH-1:0] ram_addr,
  output logic [31:0]           ram_wdata,
  output logic [3:0]            ram_be,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [31:0]           ram_rdata
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] RWAIT = 3'd3;
`ifdef AHBL_SRAM_RDATA_PIPE_EN
  localparam logic [2:0] RPIPE = 3'd4;
`endif
  localparam logic [2:0] ACK   = 3'd5;

  // One extra bit so the depth itself is representable in the compare.
  localparam logic [18:0] DEPTH = 19'(NUM_LOCATIONS);

  logic [2:0]            state_q, state_d;
  logic                  oor_q, oor_d;
  logic [3:0]            be_d;
  logic                  accept;
  logic [RAM_AWIDTH-1:0] ram_addr_q;
  logic [31:0]           ram_wdata_q;
  logic [3:0]            ram_be_q;
  logic [31:0]           rdata_q;
`ifdef AHBL_SRAM_RDATA_PIPE_EN
  logic [31:0]           rdata2_q;
`endif

  assign accept = (state_q == IDLE) && ahbsram_req;
  assign oor_d  = ({1'b0, ahbsram_addr[19:2]} >= DEPTH);

  // AHB little-endian lane selection.
  always_comb begin
    be_d = 4'b1111;
    case (ahbsram_size)
      3'd0:    be_d = 4'b0001 << ahbsram_addr[1:0];
      3'd1:    be_d = ahbsram_addr[1] ? 4'b1100 : 4'b0011;
      default: be_d = 4'b1111;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (ahbsram_req) state_d = ahbsram_write ? WRITE : READ;
      WRITE: state_d = ACK;
      READ:  state_d = RWAIT;
`ifdef AHBL_SRAM_RDATA_PIPE_EN
      RWAIT: state_d = RPIPE;
      RPIPE: state_d = ACK;
`else
      RWAIT: state_d = ACK;
`endif
      ACK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSY        = (state_q != IDLE);
    ram_we      = (state_q == WRITE) && !oor_q;
    ram_re      = (state_q == READ)  && !oor_q;
    sramahb_ack = (state_q == ACK);
  end

  // ----------------------------------------------------------- Datapath
  // SRAM command fields are loaded at acceptance so they are stable for the
  // whole strobe cycle. Byte enables/data only change on writes; an
  // out-of-range write loads zero enables so nothing can reach the array.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      oor_q       <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_be_q    <= '0;
    end else if (accept) begin
      oor_q      <= oor_d;
      ram_addr_q <= ahbsram_addr[RAM_AWIDTH+1:2];
      if (ahbsram_write) begin
        ram_wdata_q <= ahbsram_wdata;
        ram_be_q    <= oor_d ? 4'b0000 : be_d;
      end
    end
  end

  // Full word is returned; the interface stage picks the lanes it needs.
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)                rdata_q <= '0;
    else if (state_q == RWAIT)   rdata_q <= oor_q ? 32'h0 : ram_rdata;
  end

`ifdef AHBL_SRAM_RDATA_PIPE_EN
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)                rdata2_q <= '0;
    else if (state_q == RPIPE)   rdata2_q <= rdata_q;
  end
  assign sramahb_rdata = rdata2_q;
`else
  assign sramahb_rdata = rdata_q;
`endif

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_be    = ram_be_q;

endmodule
`default_nettype wire

// File: tb/tb_ahbl_sram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahbl_sram_bank_ctrl
// Purpose  : Directed self-checking bench for ahbl_sram_bank_ctrl with a
//            behavioural single-port SRAM (one-cycle read latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahbl_sram_bank_ctrl;

  logic        HCLK = 1'b0;
  logic        HRESETN = 1'b0;
  logic        ahbsram_req = 1'b0;
  logic        ahbsram_write = 1'b0;
  logic [31:0] ahbsram_wdata = '0;
  logic [2:0]  ahbsram_size = '0;
  logic [19:0] ahbsram_addr = '0;
  logic        sramahb_ack;
  logic [31:0] sramahb_rdata;
  logic        BUSY;
  logic [8:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic        ram_re;
  logic [31:0] ram_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [0:511];

  ahbl_sram_bank_ctrl #(.NUM_LOCATIONS(512), .RAM_AWIDTH(9)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .ahbsram_req(ahbsram_req), .ahbsram_write(ahbsram_write),
    .ahbsram_wdata(ahbsram_wdata), .ahbsram_size(ahbsram_size),
    .ahbsram_addr(ahbsram_addr),
    .sramahb_ack(sramahb_ack), .sramahb_rdata(sramahb_rdata), .BUSY(BUSY),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be),
    .ram_we(ram_we), .ram_re(ram_re), .ram_rdata(ram_rdata)
  );

  always #5 HCLK = ~HCLK;

  // Behavioural SRAM bank.
  always @(posedge HCLK) begin
    if (ram_we)
      for (int i = 0; i < 4; i++)
        if (ram_be[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue a write; cycle 1 carries the strobe, cycle 2 the ack.
  task automatic do_write(input string tag, input logic [19:0] a, input logic [2:0] sz,
                          input logic [31:0] d, input logic exp_we, input logic [3:0] exp_be,
                          input logic [8:0] exp_addr);
    ahbsram_req = 1'b1; ahbsram_write = 1'b1; ahbsram_addr = a;
    ahbsram_size = sz; ahbsram_wdata = d;
    tick();
    ahbsram_req = 1'b0;
    chk({tag, "_we"},   {31'b0, ram_we}, {31'b0, exp_we});
    chk({tag, "_be"},   {28'b0, ram_be}, {28'b0, exp_be});
    chk({tag, "_addr"}, {23'b0, ram_addr}, {23'b0, exp_addr});
    if (exp_we) chk({tag, "_wdata"}, ram_wdata, d);
    chk({tag, "_busy"}, {31'b0, BUSY}, 32'd1);
    tick();
    chk({tag, "_ack"},  {31'b0, sramahb_ack}, 32'd1);
    chk({tag, "_we_off"}, {31'b0, ram_we}, 32'd0);
    tick();
    chk({tag, "_idle"}, {30'b0, BUSY, sramahb_ack}, 32'd0);
  endtask

  // Issue a read; strobe in cycle 1, ack in cycle 3 (4 with the pipe stage).
  task automatic do_read(input string tag, input logic [19:0] a, input logic exp_re,
                         input logic [31:0] exp_d);
    ahbsram_req = 1'b1; ahbsram_write = 1'b0; ahbsram_addr = a; ahbsram_size = 3'd2;
    tick();
    ahbsram_req = 1'b0;
    chk({tag, "_re"}, {31'b0, ram_re}, {31'b0, exp_re});
    tick();
    chk({tag, "_noack2"}, {31'b0, sramahb_ack}, 32'd0);
`ifdef AHBL_SRAM_RDATA_PIPE_EN
    tick();
    chk({tag, "_noack3"}, {31'b0, sramahb_ack}, 32'd0);
`endif
    tick();
    chk({tag, "_ack"},   {31'b0, sramahb_ack}, 32'd1);
    chk({tag, "_rdata"}, sramahb_rdata, exp_d);
    tick();
    chk({tag, "_idle"},  {30'b0, BUSY, sramahb_ack}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;

    // Reset state.
    #2;
    chk("rst_outs", {26'b0, sramahb_ack, BUSY, ram_we, ram_re, ram_be == 4'b0, 1'b0}, 32'd2);
    chk("rst_rdata", sramahb_rdata, 32'h0);
    chk("rst_addr_wdata", {23'b0, ram_addr} | ram_wdata, 32'h0);
    tick();
    HRESETN = 1'b1;
    tick();
    chk("idle_busy", {31'b0, BUSY}, 32'd0);

    // Word write then read back.
    do_write("w_word", 20'h00010, 3'd2, 32'hDEADBEEF, 1'b1, 4'b1111, 9'd4);
    do_read ("r_word", 20'h00010, 1'b1, 32'hDEADBEEF);

    // Byte merge into an existing word.
    do_write("w_base", 20'h00010, 3'd2, 32'h11223344, 1'b1, 4'b1111, 9'd4);
    do_write("w_byte", 20'h00011, 3'd0, 32'hAAAA55AA, 1'b1, 4'b0010, 9'd4);
    do_read ("r_byte", 20'h00010, 1'b1, 32'h11225544);
    do_write("w_byte3", 20'h00013, 3'd0, 32'h77000000, 1'b1, 4'b1000, 9'd4);

    // Halfword lanes; addr[0] ignored.
    do_write("w_hw_hi", 20'h00016, 3'd1, 32'hCAFE0000, 1'b1, 4'b1100, 9'd5);
    do_write("w_hw_lo", 20'h00015, 3'd1, 32'h0000BEEF, 1'b1, 4'b0011, 9'd5);
    do_read ("r_hw",    20'h00014, 1'b1, 32'hCAFEBEEF);

    // Last in-range word, then first out-of-range word.
    do_write("w_last", 20'h007FC, 3'd7, 32'h13579BDF, 1'b1, 4'b1111, 9'd511);
    do_read ("r_last", 20'h007FC, 1'b1, 32'h13579BDF);
    do_write("w_oor",  20'h00800, 3'd2, 32'hFFFFFFFF, 1'b0, 4'b0000, 9'd0);
    do_read ("r_oor",  20'h00800, 1'b0, 32'h0);
    do_read ("r_keep", 20'h00000, 1'b1, 32'h0);
    do_read ("r_chk_last", 20'h007FC, 1'b1, 32'h13579BDF);
    do_read ("r_chk_word0", 20'h00010, 1'b1, 32'h77225544);

    // Back-to-back: req held high across the write ack into a read.
    ahbsram_req = 1'b1; ahbsram_write = 1'b1; ahbsram_addr = 20'h00020;
    ahbsram_size = 3'd2; ahbsram_wdata = 32'hA5A5A5A5;
    tick();
    chk("b2b_we", {31'b0, ram_we}, 32'd1);
    tick();
    chk("b2b_ack", {31'b0, sramahb_ack}, 32'd1);
    ahbsram_write = 1'b0;
    tick();
    chk("b2b_gap", {30'b0, BUSY, sramahb_ack}, 32'd0);
    tick();
    ahbsram_req = 1'b0;
    chk("b2b_busy", {31'b0, BUSY}, 32'd1);
    chk("b2b_re", {31'b0, ram_re}, 32'd1);
    tick();
`ifdef AHBL_SRAM_RDATA_PIPE_EN
    tick();
`endif
    tick();
    chk("b2b_rack", {31'b0, sramahb_ack}, 32'd1);
    chk("b2b_rdata", sramahb_rdata, 32'hA5A5A5A5);
    tick();

    // Reset during READ.
    ahbsram_req = 1'b1; ahbsram_write = 1'b0; ahbsram_addr = 20'h00024; ahbsram_size = 3'd2;
    tick();
    ahbsram_req = 1'b0;
    chk("mr_re", {31'b0, ram_re}, 32'd1);
    HRESETN = 1'b0;
    #1;
    chk("mr_ctl", {28'b0, sramahb_ack, BUSY, ram_we, ram_re}, 32'd0);
    chk("mr_be_addr", {19'b0, ram_be, ram_addr}, 32'd0);
    chk("mr_data", ram_wdata | sramahb_rdata, 32'h0);
    tick();
    HRESETN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mr_no_ack", {30'b0, BUSY, sramahb_ack}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
